// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, packs LSB-first dibits into bytes, marks frames.
// Optional CRC-32 FCS check is built when RMII_RX_FCS_CHECK_EN is defined; otherwise fcs_ok stays 0.
module rmii_rx_deframer #(
  parameter int MAX_BYTES = 1522,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crsdv,
  input  logic [1:0]       rxd,
  output logic [7:0]       data,
  output logic             valid,
  output logic             sof,
  output logic             eof,
  output logic             err,
  output logic [CNT_W-1:0] byte_count,
  output logic             fcs_ok
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state_q, state_d;
  logic             crsdv_q;
  logic [1:0]       rxd_q;
  logic             crsdv_p2;
  logic             vld_p2;
  logic [1:0]       rxd_p2;
  logic [5:0]       byte_sr;
  logic [1:0]       dibit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             two_low;
  logic             commit;
  logic             byte_done;
  logic             frame_end;
  logic             oversize;
  logic             clr_cnt;
  logic             frame_bad;
  logic [7:0]       byte_nxt;

  // crsdv_p2 is the carrier flag that belongs to the pending dibit in rxd_p2
  assign two_low   = !crsdv_q && !crsdv_p2;
  assign byte_nxt  = {rxd_p2, byte_sr};
  assign frame_bad = (dibit_cnt != 2'd0) || (byte_cnt == '0);

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    byte_done = 1'b0;
    frame_end = 1'b0;
    oversize  = 1'b0;
    clr_cnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (crsdv_q) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (two_low) begin
          state_d = IDLE;
        end else if (rxd_q == 2'b11) begin
          state_d = DATA;
          clr_cnt = 1'b1;
        end else if (rxd_q == 2'b10) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (vld_p2 && two_low) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end else if (vld_p2) begin
          commit = 1'b1;
          if (dibit_cnt == 2'd3) begin
            if (byte_cnt == MAX_CNT) begin
              oversize = 1'b1;
              state_d  = DROP;
            end else begin
              byte_done = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (two_low) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RMII_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_q;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // the first byte of a frame restarts from the all-ones seed
  always_ff @(posedge clk) begin
    if (byte_done) crc_q <= crc_step((byte_cnt == '0) ? 32'hFFFFFFFF : crc_q, byte_nxt);
  end
`endif

  // stage 1: input register; stage 2: pending dibit and byte assembly
  always_ff @(posedge clk) begin
    rxd_q  <= rxd;
    rxd_p2 <= rxd_q;
    if (commit) byte_sr <= {rxd_p2, byte_sr[5:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crsdv_q    <= 1'b0;
      crsdv_p2   <= 1'b0;
      vld_p2     <= 1'b0;
      dibit_cnt  <= 2'd0;
      byte_cnt   <= '0;
      data       <= 8'd0;
      valid      <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      err        <= 1'b0;
      fcs_ok     <= 1'b0;
      byte_count <= '0;
    end else begin
      state_q  <= state_d;
      crsdv_q  <= crsdv;
      crsdv_p2 <= crsdv_q;
      vld_p2   <= (state_q == DATA);
      valid    <= byte_done;
      sof      <= byte_done && (byte_cnt == '0);
      eof      <= frame_end || oversize;
      err      <= oversize || (frame_end && frame_bad);
      if (byte_done) data <= byte_nxt;
      if (clr_cnt) begin
        dibit_cnt <= 2'd0;
        byte_cnt  <= '0;
      end else if (commit) begin
        dibit_cnt <= dibit_cnt + 2'd1;
        if (byte_done) byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (frame_end) byte_count <= byte_cnt;
      else if (oversize) byte_count <= MAX_CNT;
`ifdef RMII_RX_FCS_CHECK_EN
      fcs_ok <= frame_end && !frame_bad && (crc_q == CRC_RESIDUE);
`else
      fcs_ok <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Bench for rmii_rx_deframer: directed and randomized RMII frames against a frame-level model.
module tb_rmii_rx_deframer;

  localparam int MAXB = 64;
  localparam int CW   = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          crsdv;
  logic [1:0]    rxd;
  logic [7:0]    data;
  logic          valid, sof, eof, err, fcs_ok;
  logic [CW-1:0] byte_count;

  rmii_rx_deframer #(.MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .data(data), .valid(valid),
    .sof(sof), .eof(eof), .err(err), .byte_count(byte_count), .fcs_ok(fcs_ok)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic          e;
    logic [CW-1:0] cnt;
    logic          f;
  } eof_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   collide = 0;
  logic [7:0] pay[$];
  logic [7:0] got_b[$], exp_b[$];
  logic       got_s[$], exp_s[$];
  int         got_c[$], exp_c[$];
  eof_t       got_e[$], exp_e[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    eof_t ev;
    if (valid) begin
      got_b.push_back(data);
      got_s.push_back(sof);
      got_c.push_back(cyc);
    end
    if (eof) begin
      ev.e = err; ev.cnt = byte_count; ev.f = fcs_ok;
      got_e.push_back(ev);
    end
    if (valid && eof) collide++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_reg(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, pay[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // a dibit driven in cycle c must surface as valid three cycles later
  task automatic drive(input logic c, input logic [1:0] d, input bit mark);
    @(negedge clk);
    crsdv = c;
    rxd   = d;
    if (mark) exp_c.push_back(cyc + 3);
  endtask

  task automatic send_frame(input int pre_n, input bit bad_pre, input int tail,
                            input int tog_pct, input int tog_at, input int gap);
    int   n, ndel, total;
    bit   prev_tog, tog, mark;
    logic [1:0] d;
    logic [7:0] b;
    logic [31:0] fcs;
    eof_t ev;
    for (int i = 0; i < pre_n * 4; i++) drive(1'b1, (bad_pre && i == 2) ? 2'b10 : 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0); drive(1'b1, 2'b11, 1'b0);
    n     = pay.size();
    ndel  = (n > MAXB) ? MAXB : n;
    total = n * 4 + tail;
    prev_tog = 1'b0;
    for (int j = 0; j < total; j++) begin
      if (j < n * 4) begin
        b = pay[j / 4];
        d = b[2 * (j % 4) +: 2];
      end else begin
        d = 2'($urandom);
      end
      tog  = (j != total - 1) && !prev_tog && (j == tog_at || $urandom_range(99) < tog_pct);
      mark = !bad_pre && (j < n * 4) && (j % 4 == 3) && (j / 4 < ndel);
      drive(!tog, d, mark);
      prev_tog = tog;
    end
    drive(1'b0, 2'($urandom), 1'b0);
    drive(1'b0, 2'($urandom), 1'b0);
    for (int g = 0; g < gap; g++) drive(1'b0, 2'b00, 1'b0);
    if (!bad_pre) begin
      for (int i = 0; i < ndel; i++) begin
        exp_b.push_back(pay[i]);
        exp_s.push_back(i == 0);
      end
      ev.e   = (n > MAXB) || (n == 0) || (tail != 0);
      ev.cnt = CW'(ndel);
      ev.f   = 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
      if (!ev.e && n >= 4) begin
        fcs  = ~crc_reg(n - 4);
        ev.f = (fcs == {pay[n-1], pay[n-2], pay[n-3], pay[n-4]});
      end
`endif
      exp_e.push_back(ev);
    end
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic check_batch(input string tag);
    int nb, ne;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    chk({tag, ".nbytes"}, got_b.size(), exp_b.size());
    nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("%s.byte%0d", tag, i), got_b[i], exp_b[i]);
      chk($sformatf("%s.sof%0d", tag, i), got_s[i], exp_s[i]);
      if (i < exp_c.size()) chk($sformatf("%s.lat%0d", tag, i), got_c[i], exp_c[i]);
    end
    chk({tag, ".neof"}, got_e.size(), exp_e.size());
    ne = (got_e.size() < exp_e.size()) ? got_e.size() : exp_e.size();
    for (int i = 0; i < ne; i++) begin
      chk($sformatf("%s.err%0d", tag, i), got_e[i].e, exp_e[i].e);
      chk($sformatf("%s.cnt%0d", tag, i), got_e[i].cnt, exp_e[i].cnt);
      chk($sformatf("%s.fcs%0d", tag, i), got_e[i].f, exp_e[i].f);
    end
    if (exp_e.size() > 0) chk({tag, ".held_cnt"}, byte_count, exp_e[exp_e.size()-1].cnt);
    chk({tag, ".eof_valid_overlap"}, collide, 0);
    got_b.delete(); exp_b.delete(); got_s.delete(); exp_s.delete();
    got_c.delete(); exp_c.delete(); got_e.delete(); exp_e.delete();
    collide = 0;
  endtask

  initial begin
    logic [31:0] fcs;
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", valid, 0); chk("rst.sof", sof, 0); chk("rst.eof", eof, 0);
    chk("rst.err", err, 0); chk("rst.fcs_ok", fcs_ok, 0);
    chk("rst.byte_count", byte_count, 0); chk("rst.data", data, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(7, 1'b0, 0, 0, -1, 4);
    check_batch("clean4");

    send_frame(7, 1'b0, 0, 0, 11, 4);
    check_batch("toggle4");

    pay.push_back(8'h05);
    pay = pay[0:3];
    send_frame(7, 1'b0, 2, 0, -1, 4);
    check_batch("partial");

    send_frame(7, 1'b1, 0, 0, -1, 2);
    send_frame(7, 1'b0, 0, 0, -1, 4);
    check_batch("badpre");

    pay.delete();
    send_frame(3, 1'b0, 0, 0, -1, 3);
    check_batch("empty");

    rand_pay(MAXB + 6);
    send_frame(2, 1'b0, 0, 5, -1, 2);
    rand_pay(3);
    send_frame(2, 1'b0, 0, 0, -1, 4);
    check_batch("oversize");

    rand_pay(60);
    fcs = ~crc_reg(60);
    pay.push_back(fcs[7:0]);   pay.push_back(fcs[15:8]);
    pay.push_back(fcs[23:16]); pay.push_back(fcs[31:24]);
    send_frame(7, 1'b0, 0, 5, -1, 4);
    pay[10] = pay[10] ^ 8'h04;
    send_frame(7, 1'b0, 0, 5, -1, 4);
    check_batch("fcs");

    for (int f = 0; f < 12; f++) begin
      rand_pay($urandom_range(0, 20));
      send_frame($urandom_range(1, 7), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 10, -1, $urandom_range(0, 3));
    end
    check_batch("random");

    rand_pay(20);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    for (int j = 0; j < 40; j++) drive(1'b1, pay[j / 4][2 * (j % 4) +: 2], 1'b0);
    @(negedge clk);
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    @(posedge clk);
    #1;
    chk("midrst.valid", valid, 0);
    chk("midrst.byte_count", byte_count, 0);
    got_b.delete(); got_s.delete(); got_c.delete(); got_e.delete(); collide = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_batch("midrst");

    rand_pay(6);
    send_frame(7, 1'b0, 0, 0, -1, 4);
    check_batch("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
